// File: rtl/ex_stage.sv
// Execute stage of a 5-stage pipeline: operand forwarding, ALU, halt-ecall detection
// and the EX/MEM pipeline register with stall, flush and sticky halt handling.
module ex_stage #(
    parameter logic [31:0] HALT_CODE = 32'd10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_ex_valid,
    input  logic [31:0] id_ex_rs1_data,
    input  logic [31:0] id_ex_rs2_data,
    input  logic [31:0] id_ex_imm,
    input  logic [4:0]  id_ex_rd,
    input  logic [3:0]  id_ex_alu_op,
    input  logic        id_ex_alu_src,
    input  logic        id_ex_reg_write,
    input  logic        id_ex_mem_read,
    input  logic        id_ex_mem_write,
    input  logic        id_ex_mem_to_reg,
    input  logic        id_ex_is_ecall,
    input  logic [1:0]  forward_A,
    input  logic [1:0]  forward_B,
    input  logic [1:0]  forward_ecall,
    input  logic [31:0] ex_mem_fwd_data,
    input  logic [31:0] mem_wb_fwd_data,
    input  logic [31:0] rf_x17_data,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] EX_MEM_alu_out,
    output logic [31:0] EX_MEM_dmem_data,
    output logic [4:0]  EX_MEM_rd,
    output logic        EX_MEM_valid,
    output logic        EX_MEM_reg_write,
    output logic        EX_MEM_mem_read,
    output logic        EX_MEM_mem_write,
    output logic        EX_MEM_mem_to_reg,
    output logic        EX_MEM_is_halted,
    output logic        halted
);

    logic signed [31:0] op_a;
    logic signed [31:0] fwd_b;
    logic signed [31:0] op_b;
    logic        [31:0] ecall_val;
    logic        [4:0]  shamt;
    logic        [31:0] alu_result;
    logic               halt_ecall;

    logic [31:0] alu_out_q, alu_out_d;
    logic [31:0] dmem_data_q, dmem_data_d;
    logic [4:0]  rd_q, rd_d;
    logic        valid_q, valid_d;
    logic        reg_write_q, reg_write_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        mem_to_reg_q, mem_to_reg_d;
    logic        is_halted_q, is_halted_d;
    logic        halted_q, halted_d;

    function automatic logic [31:0] fwd_sel(input logic [1:0] sel, input logic [31:0] exm,
                                            input logic [31:0] mwb, input logic [31:0] src);
        case (sel)
            2'b10:   fwd_sel = exm;
            2'b01:   fwd_sel = mwb;
            default: fwd_sel = src;
        endcase
    endfunction

    always_comb begin
        op_a      = fwd_sel(forward_A, ex_mem_fwd_data, mem_wb_fwd_data, id_ex_rs1_data);
        fwd_b     = fwd_sel(forward_B, ex_mem_fwd_data, mem_wb_fwd_data, id_ex_rs2_data);
        ecall_val = fwd_sel(forward_ecall, ex_mem_fwd_data, mem_wb_fwd_data, rf_x17_data);
        op_b      = id_ex_alu_src ? id_ex_imm : fwd_b;
        shamt     = op_b[4:0];
        halt_ecall = id_ex_valid & id_ex_is_ecall & (ecall_val == HALT_CODE);

        alu_result = 32'd0;
        case (id_ex_alu_op)
            4'd0:    alu_result = op_a + op_b;
            4'd1:    alu_result = op_a - op_b;
            4'd2:    alu_result = op_a & op_b;
            4'd3:    alu_result = op_a | op_b;
            4'd4:    alu_result = op_a ^ op_b;
            4'd5:    alu_result = op_a << shamt;
            4'd6:    alu_result = op_a >> shamt;
            4'd7:    alu_result = op_a >>> shamt;
            4'd8:    alu_result = {31'd0, op_a < op_b};
            4'd9:    alu_result = {31'd0, $unsigned(op_a) < $unsigned(op_b)};
            4'd10:   alu_result = op_b;
            default: alu_result = 32'd0;
        endcase
    end

    always_comb begin
        alu_out_d    = alu_out_q;
        dmem_data_d  = dmem_data_q;
        rd_d         = rd_q;
        valid_d      = valid_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_to_reg_d = mem_to_reg_q;
        is_halted_d  = is_halted_q;
        halted_d     = halted_q | is_halted_q;

        // Once halted, the stage only ever emits bubbles; flush also beats stall.
        if (halted_q || flush) begin
            alu_out_d    = 32'd0;
            dmem_data_d  = 32'd0;
            rd_d         = 5'd0;
            valid_d      = 1'b0;
            reg_write_d  = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            is_halted_d  = 1'b0;
        end else if (!stall) begin
            alu_out_d    = alu_result;
            dmem_data_d  = fwd_b;
            rd_d         = id_ex_rd;
            valid_d      = id_ex_valid;
            reg_write_d  = id_ex_reg_write & id_ex_valid;
            mem_read_d   = id_ex_mem_read & id_ex_valid;
            mem_write_d  = id_ex_mem_write & id_ex_valid;
            mem_to_reg_d = id_ex_mem_to_reg;
            is_halted_d  = halt_ecall;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_out_q    <= 32'd0;
            dmem_data_q  <= 32'd0;
            rd_q         <= 5'd0;
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            is_halted_q  <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            alu_out_q    <= alu_out_d;
            dmem_data_q  <= dmem_data_d;
            rd_q         <= rd_d;
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            is_halted_q  <= is_halted_d;
            halted_q     <= halted_d;
        end
    end

    assign EX_MEM_alu_out    = alu_out_q;
    assign EX_MEM_dmem_data  = dmem_data_q;
    assign EX_MEM_rd         = rd_q;
    assign EX_MEM_valid      = valid_q;
    assign EX_MEM_reg_write  = reg_write_q;
    assign EX_MEM_mem_read   = mem_read_q;
    assign EX_MEM_mem_write  = mem_write_q;
    assign EX_MEM_mem_to_reg = mem_to_reg_q;
    assign EX_MEM_is_halted  = is_halted_q;
    assign halted            = halted_q;

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have parameter HALT_CODE, default 10, the x17 value that makes an ecall a halt.
REQ-002 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port id_ex_valid, input, 1, ID/EX holds a real instruction.
REQ-005 SHALL have ports id_ex_rs1_data, id_ex_rs2_data and id_ex_imm, input, 32 each, the register-file operands and immediate.
REQ-006 SHALL have ports id_ex_rd (input, 5) and id_ex_alu_op (input, 4), giving the destination register and the ALU operation.
REQ-007 SHALL have ports id_ex_alu_src, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg and id_ex_is_ecall, input, 1 each, the control bits.
REQ-008 SHALL have ports forward_A, forward_B and forward_ecall, input, 2 each, the forwarding selects from the forwarding unit.
REQ-009 SHALL have ports ex_mem_fwd_data, mem_wb_fwd_data and rf_x17_data, input, 32 each, the forwarding sources and the register-file x17 value.
REQ-010 SHALL have ports stall (input, 1, hold EX/MEM) and flush (input, 1, bubble EX/MEM).
REQ-011 SHALL have ports EX_MEM_alu_out and EX_MEM_dmem_data, output, 32 each, the registered ALU result and store data.
REQ-012 SHALL have ports EX_MEM_rd (output, 5) and EX_MEM_valid (output, 1), the registered destination and valid bit.
REQ-013 SHALL have ports EX_MEM_reg_write, EX_MEM_mem_read, EX_MEM_mem_write and EX_MEM_mem_to_reg, output, 1 each, the registered control bits.
REQ-014 SHALL have ports EX_MEM_is_halted (output, 1, registered halt-ecall flag) and halted (output, 1, sticky halt).

Function
REQ-015 SHALL use the following operand-A select: forward_A 2'b10 picks ex_mem_fwd_data, 2'b01 picks mem_wb_fwd_data, and 2'b00 or 2'b11 picks id_ex_rs1_data.
REQ-016 SHALL apply the same select to operand B using forward_B and id_ex_rs2_data; the forwarded B value is the store data.
REQ-017 SHALL use the forwarded B value as the ALU second input when id_ex_alu_src=0, and id_ex_imm when it is 1.
REQ-018 SHALL implement alu_op encodings: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU, 10 PASS-B; codes 11-15 produce 0.
REQ-019 SHALL use only the low 5 bits of the second input as the shift amount; ADD and SUB wrap modulo 2^32.
REQ-020 SHALL select the ecall value with forward_ecall in the same way as REQ-015, substituting rf_x17_data as the 00/11 source.
REQ-021 SHALL treat a halt-ecall as id_ex_valid & id_ex_is_ecall & (ecall value == HALT_CODE).
REQ-022 SHALL, at each rising edge with no stall, no flush and halted=0, capture the ALU result, the store data, id_ex_rd, id_ex_valid, the control bits and the halt-ecall flag into the EX_MEM_* outputs (one-cycle latency).
REQ-023 SHALL force reg_write, mem_read and mem_write to 0 in the captured values when id_ex_valid=0.
REQ-024 SHALL, when stall=1 and flush=0, hold every EX_MEM_* output unchanged.
REQ-025 SHALL, when flush=1, load a bubble: EX_MEM_valid and all control bits 0, EX_MEM_is_halted 0, data fields 0; flush wins over stall.
REQ-026 SHALL set halted at the first rising edge where EX_MEM_is_halted=1, and keep it set until reset.
REQ-027 SHALL, while halted=1, load a bubble every cycle regardless of stall or flush.

Reset
REQ-028 SHALL, while reset=1, asynchronously drive every EX_MEM_* output and halted to 0.
REQ-029 SHALL, on reset release mid-operation, restart from the bubble state with no residual halt.

Verification
REQ-030 SHALL verify EX/MEM forwarding priority: rs1_data=5, ex_mem_fwd=7, mem_wb_fwd=9, forward_A=10, forward_B=00, rs2=3, ADD -> EX_MEM_alu_out=10 next edge.
REQ-031 SHALL verify the immediate path and store data: alu_src=1, imm=0xFFFFFFFF, forward_A=01, mem_wb_fwd=1, ADD, mem_write=1, rs2=0x55 -> alu_out=0, dmem_data=0x55.
REQ-032 SHALL verify stall and flush: a valid ADD is captured, then stall=1 for 2 cycles -> outputs are unchanged; then stall=1 with flush=1 -> EX_MEM_valid=0 and reg_write=0.
REQ-033 SHALL verify halt: ecall with rf_x17=0 and forward_ecall=10, ex_mem_fwd=10 -> EX_MEM_is_halted=1 at edge N, halted=1 at N+1, and subsequent valid instructions are not captured.
REQ-034 SHALL verify shift and compare: SRA with A=0x80000000 and B=0x21 -> 0xC0000000; SLT with -1 vs 1 -> 1; SLTU with -1 vs 1 -> 0.
REQ-035 SHALL verify asynchronous reset: assert reset between edges while halted=1 -> all outputs are 0 immediately; after release, a valid ADD is captured normally.
